// File: rtl/mod_n_serial_tx_if.sv
// Handshake and serial-output bundle for mod_n_serial_tx.
// master = word producer / serial consumer side, slave = the transmitter.
interface mod_n_serial_tx_if #(
  parameter int DATA_W  = 8,
  parameter int MODULUS = 5
);
  localparam int RES_W = $clog2(MODULUS);

  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic              val_o;
  logic              frame_o;
  logic              last_o;
  logic [RES_W-1:0]  mod_o;

  modport master (
    output data_i, valid_i,
    input  ready_o, val_o, frame_o, last_o, mod_o
  );

  modport slave (
    input  data_i, valid_i,
    output ready_o, val_o, frame_o, last_o, mod_o
  );
endinterface

// File: rtl/mod_n_serial_tx.sv
// MSB-first serial transmitter appending CHK_W check bits so each frame is 0 mod MODULUS.
// Optional MOD_TX_BACK2BACK_EN: accept the next word on the last check bit (no idle gap).
module mod_n_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int MODULUS = 5,
  parameter int CHK_W   = 3
) (
  input logic              clk,
  input logic              reset,
  mod_n_serial_tx_if.slave bus
);
  localparam int RES_W   = $clog2(MODULUS);
  localparam int CNT_MAX = (DATA_W > CHK_W) ? DATA_W : CHK_W;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CW      = RES_W + CHK_W;

  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CHK_LAST  = CNT_W'(CHK_W);
  localparam logic [RES_W:0]   MOD_R     = (RES_W + 1)'(MODULUS);
  localparam logic [CW-1:0]    MOD_C     = CW'(MODULUS);

  if (DATA_W < 1 || MODULUS < 2 || (2 ** CHK_W) < MODULUS) begin : g_param_err
    $error("mod_n_serial_tx: need DATA_W>=1, MODULUS>=2 and 2**CHK_W >= MODULUS");
  end

  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [CHK_W-1:0]  csr_q, csr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic              val_q, val_d;
  logic              frame_q, frame_d;
  logic              last_q, last_d;

  logic [CW-1:0]     shifted, rem;
  logic [CHK_W-1:0]  chk_val;
  logic              ready, accept;

  // (2*r + b) mod MODULUS; the sum is below 2*MODULUS, so one subtraction suffices.
  function automatic logic [RES_W-1:0] res_step(input logic [RES_W-1:0] r, input logic b);
    logic [RES_W:0] t;
    t = {r, b};
    if (t >= MOD_R) t = t - MOD_R;
    return t[RES_W-1:0];
  endfunction

  // Check value from the registered payload residue only: c = (M - (r*2**CHK_W mod M)) mod M.
  always_comb begin
    shifted = {res_q, {CHK_W{1'b0}}};
    rem     = shifted % MOD_C;
    chk_val = CHK_W'((rem == '0) ? '0 : MOD_C - rem);
  end

`ifdef MOD_TX_BACK2BACK_EN
  assign ready = (state_q == IDLE) || last_q;
`else
  assign ready = (state_q == IDLE);
`endif
  assign accept = bus.valid_i & ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    dsr_d   = dsr_q;
    csr_d   = csr_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    val_d   = 1'b0;
    frame_d = 1'b0;
    last_d  = 1'b0;

    unique case (state_q)
      IDLE: ;
      DATA: begin
        frame_d = 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = CHECK;
          val_d   = chk_val[CHK_W-1];
          csr_d   = chk_val << 1;
          res_d   = res_step(res_q, chk_val[CHK_W-1]);
          cnt_d   = CNT_W'(1);
          last_d  = (CHK_LAST == CNT_W'(1));
        end else begin
          val_d = dsr_q[DATA_W-1];
          dsr_d = dsr_q << 1;
          res_d = res_step(res_q, dsr_q[DATA_W-1]);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CHECK: begin
        if (cnt_q == CHK_LAST) begin
          state_d = IDLE;
          res_d   = '0;
          cnt_d   = '0;
        end else begin
          frame_d = 1'b1;
          val_d   = csr_q[CHK_W-1];
          csr_d   = csr_q << 1;
          res_d   = res_step(res_q, csr_q[CHK_W-1]);
          cnt_d   = cnt_q + CNT_W'(1);
          last_d  = (cnt_q + CNT_W'(1) == CHK_LAST);
        end
      end
      default: state_d = IDLE;
    endcase

    // An accepted word starts a fresh frame; the residue restarts from zero.
    if (accept) begin
      state_d = DATA;
      val_d   = bus.data_i[DATA_W-1];
      dsr_d   = bus.data_i << 1;
      res_d   = res_step('0, bus.data_i[DATA_W-1]);
      cnt_d   = CNT_W'(1);
      frame_d = 1'b1;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift registers are reset too, so no X can ever reach val_o.
      state_q <= IDLE;
      dsr_q   <= '0;
      csr_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      val_q   <= 1'b0;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      // NOTE: state updates use non-blocking assignments; blocking ones live only in always_comb.
      state_q <= state_d;
      dsr_q   <= dsr_d;
      csr_q   <= csr_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      val_q   <= val_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end

  assign bus.ready_o = ready;
  assign bus.val_o   = val_q;
  assign bus.frame_o = frame_q;
  assign bus.last_o  = last_q;
  assign bus.mod_o   = res_q;
endmodule

// File: tb/tb_mod_n_serial_tx.sv
// Scoreboard bench for mod_n_serial_tx: stimulus pushes expected frame bits, a monitor pops and compares.
module tb_mod_n_serial_tx #(
  parameter int DATA_W  = 8,
  parameter int MODULUS = 5,
  parameter int CHK_W   = 3
);
  localparam int RES_W       = $clog2(MODULUS);
  localparam int FL          = DATA_W + CHK_W;
  localparam bit DEFAULT_CFG = (DATA_W == 8) && (MODULUS == 5) && (CHK_W == 3);
`ifdef MOD_TX_BACK2BACK_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  typedef struct packed {
    logic             val;
    logic             last;
    logic [RES_W-1:0] res;
  } bit_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int       n_checks = 0;
  int       n_fail   = 0;
  bit_exp_t sb[$];
  int       gap_cnt  = 0;
  int       last_gap = -1;
  bit       in_gap   = 1'b0;

  mod_n_serial_tx_if #(.DATA_W(DATA_W), .MODULUS(MODULUS)) bus ();

  mod_n_serial_tx #(.DATA_W(DATA_W), .MODULUS(MODULUS), .CHK_W(CHK_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Smallest c in [0, MODULUS) that makes value*2**CHK_W + c divisible by MODULUS.
  function automatic int model_chk(input logic [DATA_W-1:0] d);
    longint v;
    v = longint'(d) << CHK_W;
    for (int c = 0; c < MODULUS; c++)
      if ((v + c) % MODULUS == 0) return c;
    return 0;
  endfunction

  task automatic push_frame(input logic [DATA_W-1:0] d, input int c);
    logic [FL-1:0] f;
    int            r;
    bit_exp_t      e;
    f = {d, CHK_W'(c)};
    r = 0;
    for (int i = FL - 1; i >= 0; i--) begin
      r      = (2 * r + int'(f[i])) % MODULUS;
      e.val  = f[i];
      e.last = (i == 0);
      e.res  = RES_W'(r);
      sb.push_back(e);
    end
  endtask

  // Called just after a clock edge; returns one time unit after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d, input int c, input bit hold);
    int waited;
    waited      = 0;
    bus.data_i  = d;
    bus.valid_i = 1'b1;
    while (bus.ready_o !== 1'b1 && waited < 64) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (bus.ready_o !== 1'b1) begin
      check("ready_timeout", bus.ready_o, 1);
      bus.valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    push_frame(d, c);
    #1;
    if (!hold) bus.valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.frame_o !== 1'b0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_ready_idle"}, bus.ready_o, 1);
  endtask

  // Hand-computed check values hold for the default configuration only.
  task automatic directed(input logic [7:0] d8, input int c_hand);
    logic [DATA_W-1:0] d;
    d = DATA_W'(d8);
    send(d, DEFAULT_CFG ? c_hand : model_chk(d), 1'b0);
    wait_drain("directed");
  endtask

  always @(negedge clk) begin
    bit_exp_t e;
    if (!reset) begin
      if (bus.frame_o === 1'b1) begin
        if (in_gap) begin
          last_gap = gap_cnt;
          in_gap   = 1'b0;
        end
        check("frame_bit_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("val_o", bus.val_o, e.val);
          check("last_o", bus.last_o, e.last);
          check("mod_o", bus.mod_o, e.res);
        end
        if (bus.last_o === 1'b1) begin
          in_gap  = 1'b1;
          gap_cnt = 0;
        end
      end else begin
        check("idle_val_o", bus.val_o, 0);
        check("idle_last_o", bus.last_o, 0);
        check("idle_mod_o", bus.mod_o, 0);
        if (in_gap) gap_cnt++;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_val_o", bus.val_o, 0);
    check("rst_frame_o", bus.frame_o, 0);
    check("rst_last_o", bus.last_o, 0);
    check("rst_mod_o", bus.mod_o, 0);
    check("rst_ready_o", bus.ready_o, 1);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;

    // 01 -> check 010 (frame 10), 07 -> 100 (frame 60), FF -> 000, 00 -> 000
    directed(8'h01, 2);
    directed(8'h07, 4);
    directed(8'hFF, 0);
    directed(8'h00, 0);

    // Abort A5 on its 4th payload bit; outputs must clear before any clock edge.
    send(DATA_W'(8'hA5), DEFAULT_CFG ? 0 : model_chk(DATA_W'(8'hA5)), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_frame_o", bus.frame_o, 1);
    #1 reset = 1'b1;
    #1;
    check("abort_val_o", bus.val_o, 0);
    check("abort_frame_o", bus.frame_o, 0);
    check("abort_last_o", bus.last_o, 0);
    check("abort_mod_o", bus.mod_o, 0);
    check("abort_ready_o", bus.ready_o, 1);
    sb.delete();
    in_gap = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    directed(8'h01, 2);

    // valid_i held high across two words: 03 -> check 001, 04 -> check 011.
    last_gap = -1;
    send(DATA_W'(8'h03), DEFAULT_CFG ? 1 : model_chk(DATA_W'(8'h03)), 1'b1);
    send(DATA_W'(8'h04), DEFAULT_CFG ? 3 : model_chk(DATA_W'(8'h04)), 1'b0);
    wait_drain("b2b");
    check("b2b_gap", last_gap, EXP_GAP);

    for (int k = 0; k < 500; k++) begin
      logic [DATA_W-1:0] d;
      d = DATA_W'($urandom);
      send(d, model_chk(d), ($urandom_range(0, 1) == 1));
    end
    bus.valid_i = 1'b0;
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
